cmp_event_capture: RTL and testbench

CMP_EVENT_CAPTURE -- requirements
Module: cmp_event_capture

---
 rtl/cmp_event_capture.sv | 137 +++++++++++++
 tb/tb_cmp_event_capture.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cmp_event_capture.sv
// cmp_event_capture
//   Synchronizes an asynchronous latch-comparator decision and glitch-filters
//   it. Every change of the filtered level is timestamped and queued in a
//   small event FIFO.
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      asynchronous active-low reset
//   ena        block enable; 0 freezes sync flops, filter and timestamp
//   cmp_in     raw comparator decision (asynchronous to clk)
//   filt_len   required consecutive stable samples (0 acts as 1)
//   cmp_filt   synchronized, glitch-filtered comparator level
//   evt_valid  FIFO head holds an event
//   evt_ready  consumer accepts the head event
//   evt_data   {edge, timestamp}; edge 1 = rising, 0 = falling
//   evt_count  FIFO occupancy, 0..DEPTH
//   ovf        sticky overflow flag (event dropped while full)
//   ovf_clr    synchronous clear of ovf
module cmp_event_capture #(
  parameter int FILT_W = 4,
  parameter int TS_W   = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       cmp_in,
  input  logic [FILT_W-1:0]          filt_len,
  output logic                       cmp_filt,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [TS_W:0]              evt_data,
  output logic [$clog2(DEPTH):0]     evt_count,
  output logic                       ovf,
  input  logic                       ovf_clr
);

  localparam int AW = $clog2(DEPTH);

  // A programmed length of zero behaves like a single-sample filter.
  function automatic logic [FILT_W-1:0] eff_len(input logic [FILT_W-1:0] len);
    return (len == '0) ? FILT_W'(1) : len;
  endfunction

  logic              cmp_meta_p0;
  logic              cmp_s_p1;
  logic [FILT_W-1:0] filt_cnt;
  logic [TS_W-1:0]   ts;
  logic [FILT_W:0]   cnt_inc;
  logic              filt_hit;

  logic              vld_p2;
  logic [TS_W:0]     data_p2;

  logic [TS_W:0]     mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              full;
  logic              pop;
  logic              push_ok;
  logic              ovf_set;

  // Stage p0/p1: two-flop synchronizer, frozen while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_meta_p0 <= 1'b0;
      cmp_s_p1    <= 1'b0;
    end else if (ena) begin
      cmp_meta_p0 <= cmp_in;
      cmp_s_p1    <= cmp_meta_p0;
    end
  end

  // Counter is one bit wider so the increment never wraps before the compare.
  assign cnt_inc  = {1'b0, filt_cnt} + (FILT_W + 1)'(1);
  assign filt_hit = (cmp_s_p1 != cmp_filt) && (cnt_inc == {1'b0, eff_len(filt_len)});

  // Stage p2: glitch filter and timestamp; a level change stages one event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_cnt <= '0;
      cmp_filt <= 1'b0;
      ts       <= '0;
      vld_p2   <= 1'b0;
    end else begin
      vld_p2 <= 1'b0;
      if (ena) begin
        ts <= ts + TS_W'(1);
        if (cmp_s_p1 == cmp_filt) begin
          filt_cnt <= '0;
        end else if (filt_hit) begin
          cmp_filt <= cmp_s_p1;
          filt_cnt <= '0;
          vld_p2   <= 1'b1;
        end else begin
          filt_cnt <= cnt_inc[FILT_W-1:0];
        end
      end
    end
  end

  // Event payload carries the timestamp from before the filter edge.
  always_ff @(posedge clk) begin
    if (ena && filt_hit) data_p2 <= {cmp_s_p1, ts};
  end

  // Stage p3: event FIFO write/read
  assign evt_count = wr_ptr - rd_ptr;
  assign evt_valid = (evt_count != '0);
  assign full      = (evt_count == (AW + 1)'(DEPTH));
  assign pop       = evt_valid && evt_ready;
  // A pop frees the slot that a simultaneous push into a full FIFO reuses.
  assign push_ok   = vld_p2 && (!full || pop);
  assign ovf_set   = vld_p2 && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW + 1)'(1);
      // A new overflow wins over a coincident clear.
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= data_p2;
  end

  // Storage is not reset, so the head is masked to zero when empty.
  assign evt_data = evt_valid ? mem[rd_ptr[AW-1:0]] : '0;

endmodule

// File: tb/tb_cmp_event_capture.sv
// tb_cmp_event_capture
//   Directed bench for cmp_event_capture (FILT_W=4, TS_W=8, DEPTH=4).
//   Inputs change and outputs are sampled 1 ns after the rising edge.
module tb_cmp_event_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       cmp_in;
  logic [3:0] filt_len;
  logic       cmp_filt;
  logic       evt_valid;
  logic       evt_ready;
  logic [8:0] evt_data;
  logic [2:0] evt_count;
  logic       ovf;
  logic       ovf_clr;

  int tests = 0;
  int fails = 0;

  // Reference timestamp: number of enabled edges since reset, mod 256.
  logic [7:0] ts_m;

  logic [8:0] exps [5];
  logic [8:0] exp_a;
  logic [8:0] exp_b;

  cmp_event_capture #(.FILT_W(4), .TS_W(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .cmp_in    (cmp_in),
    .filt_len  (filt_len),
    .cmp_filt  (cmp_filt),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_data  (evt_data),
    .evt_count (evt_count),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ts_m <= 8'd0;
    else if (ena) ts_m <= ts_m + 8'd1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [8:0] exp);
    chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
    chk({tag, "_data"}, 32'(evt_data), 32'(exp));
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
  endtask

  // Step cmp_in for filt_len=1; the event carries the ts two edges later.
  task automatic step1(input logic v, output logic [8:0] exp);
    cmp_in = v;
    exp = {v, 8'(ts_m + 8'd2)};
    tick(4);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; cmp_in = 1'b0; filt_len = 4'd3;
    evt_ready = 1'b0; ovf_clr = 1'b0;
    tick(3);
    chk("rst_filt",  32'(cmp_filt),  32'd0);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_count", 32'(evt_count), 32'd0);
    chk("rst_data",  32'(evt_data),  32'd0);
    chk("rst_ovf",   32'(ovf),       32'd0);
    rst_n = 1'b1;

    // Clean step at cycle 10: cmp_filt at 15, event at 16 with ts 14
    tick(10);
    cmp_in = 1'b1;
    tick(4);
    chk("step_filt_c14", 32'(cmp_filt), 32'd0);
    tick(1);
    chk("step_filt_c15", 32'(cmp_filt), 32'd1);
    chk("step_valid_c15", 32'(evt_valid), 32'd0);
    tick(1);
    chk("step_count_c16", 32'(evt_count), 32'd1);
    pop_chk("step_evt", 9'h10E);
    chk("step_count_pop", 32'(evt_count), 32'd0);
    cmp_in = 1'b0;
    exp_a = {1'b0, 8'(ts_m + 8'd4)};
    tick(6);
    pop_chk("fall_evt", exp_a);

    // Short pulse rejected at filt_len=3
    cmp_in = 1'b1;
    tick(2);
    cmp_in = 1'b0;
    tick(8);
    chk("pulse_filt",  32'(cmp_filt),  32'd0);
    chk("pulse_count", 32'(evt_count), 32'd0);

    // filt_len=0 acts as 1: a one-cycle pulse yields rise and fall events
    filt_len = 4'd0;
    cmp_in = 1'b1;
    exp_a = {1'b1, 8'(ts_m + 8'd2)};
    exp_b = {1'b0, 8'(ts_m + 8'd3)};
    tick(1);
    cmp_in = 1'b0;
    tick(6);
    chk("len0_count", 32'(evt_count), 32'd2);
    pop_chk("len0_rise", exp_a);
    pop_chk("len0_fall", exp_b);

    // Overflow: five edges into a four-deep FIFO
    filt_len = 4'd1;
    for (int i = 0; i < 5; i++) step1(~i[0], exps[i]);
    chk("ovf_count", 32'(evt_count), 32'd4);
    chk("ovf_set",   32'(ovf),       32'd1);
    for (int i = 0; i < 4; i++) pop_chk($sformatf("ovf_pop%0d", i), exps[i]);
    chk("ovf_empty",  32'(evt_valid), 32'd0);
    chk("ovf_sticky", 32'(ovf),       32'd1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'd0);

    // Full FIFO: push and pop on the same edge
    for (int i = 0; i < 4; i++) step1(i[0], exps[i]);
    chk("full_count", 32'(evt_count), 32'd4);
    cmp_in = 1'b0;
    exp_a = {1'b0, 8'(ts_m + 8'd2)};
    tick(3);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    chk("pp_count", 32'(evt_count), 32'd4);
    chk("pp_ovf",   32'(ovf),       32'd0);
    for (int i = 1; i < 4; i++) pop_chk($sformatf("pp_pop%0d", i), exps[i]);
    pop_chk("pp_tail", exp_a);

    // Timestamp wrap: event at ts 255, next at ts 3
    for (int n = 0; n < 300 && ts_m != 8'd253; n++) tick(1);
    chk("wrap_reach", 32'(ts_m), 32'd253);
    cmp_in = 1'b1;
    tick(4);
    cmp_in = 1'b0;
    tick(4);
    pop_chk("wrap_ff", 9'h1FF);
    pop_chk("wrap_03", 9'h003);

    // ena=0 freezes filter and timestamp; FIFO pop still works
    step1(1'b1, exp_a);
    ena = 1'b0;
    cmp_in = 1'b0;
    tick(10);
    chk("ena_filt",  32'(cmp_filt),  32'd1);
    chk("ena_count", 32'(evt_count), 32'd1);
    pop_chk("ena_pop", exp_a);
    chk("ena_empty", 32'(evt_count), 32'd0);
    ena = 1'b1;
    exp_b = {1'b0, 8'(ts_m + 8'd2)};
    tick(4);
    pop_chk("ena_resume", exp_b);

    // Reset with three queued events
    step1(1'b1, exps[0]);
    step1(1'b0, exps[1]);
    step1(1'b1, exps[2]);
    chk("pre_rst_count", 32'(evt_count), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("rst2_valid", 32'(evt_valid), 32'd0);
    chk("rst2_count", 32'(evt_count), 32'd0);
    chk("rst2_ovf",   32'(ovf),       32'd0);
    chk("rst2_filt",  32'(cmp_filt),  32'd0);
    chk("rst2_data",  32'(evt_data),  32'd0);
    filt_len = 4'd3;
    tick(1);
    rst_n = 1'b1;
    tick(4);
    chk("restart_filt_c4", 32'(cmp_filt), 32'd0);
    tick(1);
    chk("restart_filt_c5", 32'(cmp_filt), 32'd1);
    tick(1);
    chk("restart_count", 32'(evt_count), 32'd1);
    pop_chk("restart_evt", 9'h104);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
